exec_issue_ctrl: RTL
====================

// Module: exec_issue_ctrl
// PURPOSE
// Issue controller between decode and exec_int: buffers decoded instructions in a DEPTH-entry FIFO and
// issues at most one per cycle to exec_int. Blocks issue on RAW hazards against in-flight results,
// registers writebacks, and halts the pipeline on an exec_int exception until the front end resumes or flushes.
// PARAMETERS
// DEPTH  4  FIFO entries; power of two, >=2. XLEN/ALEN come from params.svh.
// PORTS
// clk                      in   1          clock
// rst                      in   1          synchronous reset, active-low (0 = reset)
// decode_valid             in   1          decode presents an instruction
// decode_ready             out  1          FIFO can accept this cycle
// decode_instruction_addr  in   ALEN       instruction address
// decode_{opcode,rd,funct3,rs1,rs2,funct7,u_imm}  in  5,5,3,5,5,7,20  decoded fields
// issue_valid              out  1          drives exec_int input_valid (input_is_int tied 1 at top)
// issue_{addr,opcode,rd,funct3,rs1,rs2,funct7,u_imm}  out  ALEN,5,5,3,5,5,7,20  FIFO head fields
// exec_int_output_valid    in   1          exec_int result valid (1 cycle after issue)
// exec_int_exception       in   1          exec_int exception flag
// exec_int_result          in   XLEN       exec_int result
// wb_valid                 out  1          register write this cycle
// wb_rd                    out  5          destination register
// wb_data                  out  XLEN       write data
// exc_valid                out  1          one-cycle exception pulse
// exc_addr                 out  ALEN       faulting instruction address
// flush                    in   1          discard all queued/in-flight work, return to RUN
// resume                   in   1          leave HALT
// busy                     out  1          FIFO non-empty or any tracker slot valid
// BEHAVIOUR
// - Reset (rst==0 at posedge): FIFO empty, pointers 0, trackers invalid, state RUN.
//   wb_valid=0, exc_valid=0, wb_rd=0, wb_data=0, exc_addr=0.
// - States: RUN (accept + issue) and HALT (no accept, no issue).
//   - RUN->HALT on an accepted exception.
//   - HALT->RUN on resume or flush.
//   - flush wins over everything in the same cycle.
// - Enqueue: decode_ready = (state==RUN) && (count<DEPTH) && !flush.
//   - Depends on count only: a full FIFO refuses even when the head issues in the same cycle.
//   - Pointers wrap mod DEPTH. Count width is clog2(DEPTH)+1.
// - Issue (combinational from head): issue_valid = RUN && !empty && !hazard && !flush && !exc_now.
//   - exc_now = exec_int_output_valid && exec_int_exception && s1 valid.
//   - Dequeue occurs when issue_valid.
//   - issue_* fields show the head regardless of issue_valid.
// - Trackers:
//   - s1 = {valid, rd, addr} of the instruction issued last cycle.
//   - s2 = copy of s1 from the previous cycle (result being written back).
//   - Per cycle: s2<=s1; s1<=issued ? head : invalid.
// - Hazard: head rs1 or rs2 is nonzero and equals the rd of a valid s1 or s2 slot with rd!=0.
//   - No forwarding: a dependent instruction issues at the earliest 3 cycles after its producer.
// - Writeback (registered): when exec_int_output_valid && s1.valid && !exec_int_exception,
//   next cycle wb_valid=1, wb_rd=s1.rd, wb_data=exec_int_result. Otherwise wb_valid=0.
//   - exec_int_output_valid with s1 invalid (squashed) is ignored.
// - Exception: when exec_int_output_valid && exec_int_exception && s1.valid:
//   - next cycle exc_valid=1 and exc_addr=s1.addr;
//   - FIFO cleared and s1 invalidated the same edge; state->HALT.
//   - No wb for the faulting instruction.
// - flush: clears FIFO, s1, s2 and any pending wb (wb_valid=0 next cycle); state->RUN. Issue is suppressed during the flush cycle.
// - resume in RUN has no effect. decode_valid while !decode_ready is ignored; decode must hold it.
// - busy = !empty || s1.valid || s2.valid.
// TESTING
// 1 Reset: hold rst=0 for 2 cycles with decode_valid=1 -> decode_ready=0, issue_valid=0, wb_valid=0, exc_valid=0.
// 2 Fill: push 5 LUIs (x1..x5) with exec stub stalled by hazard-free ops -> decode_ready drops after 4 accepts;
//   then drains in order. LUI x1 0x12345 -> wb x1=0x12345000 two cycles after issue.
// 3 RAW: LUI x3 then op with rs1=x3 -> second issue_valid 3 cycles after first; rs1=x0 dependency -> no stall.
// 4 Exception: non-LUI at addr 0x100 followed by 2 queued ops -> exc_valid pulse, exc_addr=0x100, no wb,
//   FIFO empty, decode_ready=0 until resume, then RUN.
// 5 Flush: flush asserted while full with one op in s1 -> next cycle busy=0, no wb for the squashed op, decode_ready=1.
// 6 Corners: enqueue+dequeue at count=DEPTH-1 keeps count; pointer wrap after 9 pushes keeps FIFO order;
//   flush+resume in HALT -> RUN, FIFO empty.

Source files
------------

// File: rtl/exec_issue_ctrl.sv
// exec_issue_ctrl: FIFO-buffered in-order issue to exec_int with RAW stall, registered writeback and exception halt
module exec_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int ALEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            decode_valid,
    output logic            decode_ready,
    input  logic [ALEN-1:0] decode_instruction_addr,
    input  logic [4:0]      decode_opcode,
    input  logic [4:0]      decode_rd,
    input  logic [2:0]      decode_funct3,
    input  logic [4:0]      decode_rs1,
    input  logic [4:0]      decode_rs2,
    input  logic [6:0]      decode_funct7,
    input  logic [19:0]     decode_u_imm,
    output logic            issue_valid,
    output logic [ALEN-1:0] issue_addr,
    output logic [4:0]      issue_opcode,
    output logic [4:0]      issue_rd,
    output logic [2:0]      issue_funct3,
    output logic [4:0]      issue_rs1,
    output logic [4:0]      issue_rs2,
    output logic [6:0]      issue_funct7,
    output logic [19:0]     issue_u_imm,
    input  logic            exec_int_output_valid,
    input  logic            exec_int_exception,
    input  logic [XLEN-1:0] exec_int_result,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exc_valid,
    output logic [ALEN-1:0] exc_addr,
    input  logic            flush,
    input  logic            resume,
    output logic            busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [0:0] RUN = 1'b0, HALT = 1'b1;
    typedef struct packed {
        logic [ALEN-1:0] addr;
        logic [4:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      funct7;
        logic [19:0]     u_imm;
    } entry_t;
    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [0:0]      state;
    logic            s1_valid, s2_valid;
    logic [4:0]      s1_rd, s2_rd;
    logic [ALEN-1:0] s1_addr;
    logic            empty, push, hazard, exc_now, wb_now;
    assign head         = mem[rd_ptr];
    assign empty        = count == '0;
    assign exc_now      = exec_int_output_valid && exec_int_exception && s1_valid;
    assign wb_now       = exec_int_output_valid && !exec_int_exception && s1_valid && !flush;
    // x0 never creates a dependency, whether as source or as destination
    assign hazard       = (head.rs1 != 5'd0 && ((s1_valid && s1_rd == head.rs1) || (s2_valid && s2_rd == head.rs1)))
                       || (head.rs2 != 5'd0 && ((s1_valid && s1_rd == head.rs2) || (s2_valid && s2_rd == head.rs2)));
    assign decode_ready = rst && state == RUN && count != FULL && !flush;
    assign issue_valid  = rst && state == RUN && !empty && !hazard && !flush && !exc_now;
    assign push         = decode_valid && decode_ready;
    assign busy         = !empty || s1_valid || s2_valid;
    assign issue_addr   = head.addr;
    assign issue_opcode = head.opcode;
    assign issue_rd     = head.rd;
    assign issue_funct3 = head.funct3;
    assign issue_rs1    = head.rs1;
    assign issue_rs2    = head.rs2;
    assign issue_funct7 = head.funct7;
    assign issue_u_imm  = head.u_imm;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {decode_instruction_addr, decode_opcode, decode_rd, decode_funct3,
                                  decode_rs1, decode_rs2, decode_funct7, decode_u_imm};
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= RUN;
            s1_valid  <= 1'b0;
            s1_rd     <= '0;
            s1_addr   <= '0;
            s2_valid  <= 1'b0;
            s2_rd     <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            exc_valid <= 1'b0;
            exc_addr  <= '0;
        end else begin
            s2_valid  <= s1_valid && !flush;
            s2_rd     <= s1_rd;
            s1_valid  <= issue_valid;
            s1_rd     <= head.rd;
            s1_addr   <= head.addr;
            wb_valid  <= wb_now;
            exc_valid <= exc_now && !flush;
            state     <= flush ? RUN : exc_now ? HALT : resume ? RUN : state;
            if (wb_now) begin
                wb_rd   <= s1_rd;
                wb_data <= exec_int_result;
            end
            if (exc_now && !flush) exc_addr <= s1_addr;
            if (flush || exc_now) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                wr_ptr <= wr_ptr + AW'(push);
                rd_ptr <= rd_ptr + AW'(issue_valid);
                count  <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue_valid};
            end
        end
    end
endmodule
